// File: rtl/cpu_defs_pkg.sv
// Shared decode constants, divider state encoding and ALU helper
// for the RV32IM execute stage.
package cpu_defs_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_CALC,
        DIV_DONE
    } div_state_t;

    function automatic logic [31:0] alu_calc(
        input logic [2:0]  f3,
        input logic        alt,
        input logic        sub,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [31:0]        r;
        logic signed [31:0] sra;
        logic [4:0]         sh;
        sh  = b[4:0];
        sra = $signed(a) >>> sh;
        unique case (f3)
            F3_ADD:  r = sub ? a - b : a + b;
            F3_SLL:  r = a << sh;
            F3_SLT:  r = {31'b0, $signed(a) < $signed(b)};
            F3_SLTU: r = {31'b0, a < b};
            F3_XOR:  r = a ^ b;
            F3_SR:   r = alt ? sra : a >> sh;
            F3_OR:   r = a | b;
            F3_AND:  r = a & b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ex_div.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU, one quotient
// bit per cycle, with zero-divisor and overflow short-cuts.
module ex_div
    import cpu_defs_pkg::*;
#(
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        signed_op,
    input  logic        rem_op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam logic [5:0] LAST = 6'(DIV_ITERS - 1);

    div_state_t  state;
    logic [5:0]  cnt;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] dvs;
    logic [31:0] res;
    logic        neg_q;
    logic        neg_r;
    logic        is_rem;

    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        ovf;
    logic [32:0] r_sh;
    logic [32:0] diff;
    logic        fits;
    logic [31:0] q_nx;
    logic [31:0] r_nx;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    assign a_neg = signed_op & dividend[31];
    assign b_neg = signed_op & divisor[31];
    assign a_mag = a_neg ? -dividend : dividend;
    assign b_mag = b_neg ? -divisor : divisor;
    assign ovf   = signed_op & (dividend == 32'h8000_0000)
                 & (divisor == 32'hFFFF_FFFF);

    // Shift the next dividend bit into the partial remainder and
    // keep the subtraction only if it does not borrow.
    assign r_sh  = {rem, quo[31]};
    assign diff  = r_sh - {1'b0, dvs};
    assign fits  = ~diff[32];
    assign q_nx  = {quo[30:0], fits};
    assign r_nx  = fits ? diff[31:0] : r_sh[31:0];
    assign q_fix = neg_q ? -q_nx : q_nx;
    assign r_fix = neg_r ? -r_nx : r_nx;

    assign busy   = ~flush & (((state == DIV_IDLE) & start)
                            | (state == DIV_CALC));
    assign done   = ~flush & (state == DIV_DONE);
    assign result = res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= DIV_IDLE;
            cnt    <= '0;
            quo    <= '0;
            rem    <= '0;
            dvs    <= '0;
            res    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            is_rem <= 1'b0;
        end else if (flush) begin
            state <= DIV_IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                DIV_IDLE: begin
                    if (start) begin
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        is_rem <= rem_op;
                        quo    <= a_mag;
                        dvs    <= b_mag;
                        rem    <= '0;
                        cnt    <= '0;
                        if (divisor == '0) begin
                            res   <= rem_op ? dividend : 32'hFFFF_FFFF;
                            state <= DIV_DONE;
                        end else if (ovf) begin
                            res   <= rem_op ? 32'h0 : 32'h8000_0000;
                            state <= DIV_DONE;
                        end else begin
                            state <= DIV_CALC;
                        end
                    end
                end
                DIV_CALC: begin
                    quo <= q_nx;
                    rem <= r_nx;
                    cnt <= cnt + 6'd1;
                    if (cnt == LAST) begin
                        res   <= is_rem ? r_fix : q_fix;
                        state <= DIV_DONE;
                    end
                end
                DIV_DONE: state <= DIV_IDLE;
                default:  state <= DIV_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ex_unit.sv
// RV32IM execute stage: ALU, single-cycle multiplier, branch/jump
// resolution, memory address generation and the divider.
module ex_unit
    import cpu_defs_pkg::*;
#(
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] alu_op1,
    input  logic [31:0] alu_op2,
    input  logic [31:0] alu_reg1_data,
    input  logic [31:0] alu_reg2_data,
    input  logic [31:0] alu_op1_jump,
    input  logic [31:0] alu_op2_jump,
    input  logic        alu_wr_reg_en,
    input  logic [4:0]  alu_wr_reg_addr,
    input  logic [31:0] alu_pc,
    input  logic [31:0] alu_inst,
    input  logic [5:0]  stall,
    output logic        ex_wr_reg_en,
    output logic [4:0]  ex_wr_reg_addr,
    output logic [31:0] ex_wr_data,
    output logic        ex_jump_flag,
    output logic [31:0] ex_jump_addr,
    output logic [31:0] ex_mem_addr,
    output logic [31:0] ex_mem_wdata,
    output logic [31:0] ex_inst,
    output logic        ex_stall_req
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       flush;
    logic       valid;
    logic       unused_bits;

    assign opc   = alu_inst[6:0];
    assign f3    = alu_inst[14:12];
    assign f7    = alu_inst[31:25];
    assign flush = (stall == 6'b111111);
    // Outputs stay quiet in reset and for bubbles.
    assign valid = rst_n & (alu_inst != '0);
    assign unused_bits = ^{alu_inst[24:15], alu_inst[11:7]};

    logic is_op, is_m, is_alu, is_mul, is_div, is_opi;
    logic is_upper, is_jal, is_jalr, is_br, is_ls;

    assign is_op    = (opc == OPC_OP);
    assign is_m     = is_op & (f7 == F7_MULDIV);
    assign is_alu   = is_op & ((f7 == F7_BASE) | (f7 == F7_ALT));
    assign is_mul   = is_m & ~f3[2];
    assign is_div   = is_m & f3[2];
    assign is_opi   = (opc == OPC_OP_IMM);
    assign is_upper = (opc == OPC_LUI) | (opc == OPC_AUIPC);
    assign is_jal   = (opc == OPC_JAL);
    assign is_jalr  = (opc == OPC_JALR);
    assign is_br    = (opc == OPC_BRANCH);
    assign is_ls    = (opc == OPC_LOAD) | (opc == OPC_STORE);

    logic [31:0] alu_res;
    assign alu_res = alu_calc(f3, alu_inst[30], is_op & alu_inst[30],
                              alu_op1, alu_op2);

    logic        sa;
    logic        sb;
    logic [63:0] ma;
    logic [63:0] mb;
    logic [63:0] prod;
    logic [31:0] mul_res;

    assign sa   = (f3 == F3_MULH) | (f3 == F3_MULHSU);
    assign sb   = (f3 == F3_MULH);
    assign ma   = {{32{sa & alu_op1[31]}}, alu_op1};
    assign mb   = {{32{sb & alu_op2[31]}}, alu_op2};
    assign prod = ma * mb;
    assign mul_res = (f3 == F3_MUL) ? prod[31:0] : prod[63:32];

    logic        div_busy;
    logic        div_done;
    logic [31:0] div_res;

    ex_div #(
        .DIV_ITERS (DIV_ITERS)
    ) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (is_div),
        .signed_op (~f3[0]),
        .rem_op    (f3[1]),
        .dividend  (alu_op1),
        .divisor   (alu_op2),
        .flush     (flush),
        .busy      (div_busy),
        .done      (div_done),
        .result    (div_res)
    );

    logic taken;
    always_comb begin
        taken = 1'b0;
        unique case (f3)
            F3_BEQ:  taken = (alu_reg1_data == alu_reg2_data);
            F3_BNE:  taken = (alu_reg1_data != alu_reg2_data);
            F3_BLT:  taken = ($signed(alu_reg1_data) < $signed(alu_reg2_data));
            F3_BGE:  taken = ($signed(alu_reg1_data) >= $signed(alu_reg2_data));
            F3_BLTU: taken = (alu_reg1_data < alu_reg2_data);
            F3_BGEU: taken = (alu_reg1_data >= alu_reg2_data);
            default: taken = 1'b0;
        endcase
    end

    logic [31:0] wdata;
    always_comb begin
        wdata = '0;
        unique case (1'b1)
            is_alu, is_opi:  wdata = alu_res;
            is_mul:          wdata = mul_res;
            is_div:          wdata = div_done ? div_res : '0;
            is_upper:        wdata = alu_op1 + alu_op2;
            is_jal, is_jalr: wdata = alu_pc + 32'd4;
            default:         wdata = '0;
        endcase
    end

    logic        jflag;
    logic [31:0] jsum;
    assign jflag = is_jal | is_jalr | (is_br & taken);
    assign jsum  = alu_op1_jump + alu_op2_jump;

    assign ex_stall_req   = valid & div_busy;
    assign ex_wr_reg_en   = valid & alu_wr_reg_en & ~ex_stall_req;
    assign ex_wr_reg_addr = valid ? alu_wr_reg_addr : '0;
    assign ex_wr_data     = valid ? wdata : '0;
    assign ex_jump_flag   = valid & jflag;
    assign ex_jump_addr   = (valid & jflag)
                          ? (is_jalr ? {jsum[31:1], 1'b0} : jsum) : '0;
    assign ex_mem_addr    = (valid & is_ls) ? alu_op1 + alu_op2 : '0;
    assign ex_mem_wdata   = (valid & is_ls) ? alu_reg2_data : '0;
    assign ex_inst        = rst_n ? alu_inst : '0;

endmodule

// File: doc/ex_unit.md
EX_UNIT -- requirements
Module: ex_unit

Interface
Parameters:
REQ-001 DIV_ITERS, 32, divider iterations per DIV/DIVU/REM/REMU; only 32 is supported.

Ports:
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 alu_op1, alu_op2  in  32 each  ALU operands from the decode/execute register.
REQ-005 alu_reg1_data, alu_reg2_data  in  32 each  rs1/rs2 values, used for branch compare and store data.
REQ-006 alu_op1_jump, alu_op2_jump  in  32 each  target-address addends.
REQ-007 alu_wr_reg_en / alu_wr_reg_addr  in  1 / 5  rd write request.
REQ-008 alu_pc, alu_inst  in  32 each  instruction address and word; zero means bubble.
REQ-009 stall  in  6  pipeline control; 6'b111111 means flush.
REQ-010 ex_wr_reg_en / ex_wr_reg_addr / ex_wr_data  out  1 / 5 / 32  writeback request to the next stage.
REQ-011 ex_jump_flag / ex_jump_addr  out  1 / 32  redirect request to PC/control.
REQ-012 ex_mem_addr, ex_mem_wdata  out  32 each  load/store address and store data.
REQ-013 ex_inst  out  32  alu_inst passed through.
REQ-014 ex_stall_req  out  1  request to hold PC, IF/DE and DE/EX.

Function
REQ-015 Decode from alu_inst opcode/funct3/funct7.
- RV32I OP/OP-IMM/LUI/AUIPC results: combinational, same cycle.
- ex_wr_reg_en = alu_wr_reg_en, except forced 0 while ex_stall_req=1.
REQ-016 Shift amount = alu_op2[4:0]; SRA sign-fills; SLT is signed, SLTU unsigned.
REQ-017 MUL/MULH/MULHSU/MULHU: single-cycle.
- Product is 64 bits; MUL returns [31:0], the others return [63:32].
- Operand signedness per RV32M.
REQ-018 BEQ/BNE/BLT/BGE/BLTU/BGEU compare alu_reg1_data with alu_reg2_data.
- When taken: ex_jump_flag=1, ex_jump_addr = alu_op1_jump + alu_op2_jump (mod 2^32).
REQ-019 JAL/JALR: ex_jump_flag=1; ex_wr_data = alu_pc+4.
- JALR clears ex_jump_addr[0].
REQ-020 Loads/stores: ex_mem_addr = alu_op1+alu_op2; ex_mem_wdata = alu_reg2_data.
- Both are 0 for other instructions.
REQ-021 DIV/DIVU/REM/REMU use a divider FSM with states IDLE, CALC, DONE.
REQ-022 IDLE, divide present:
- Latch magnitudes and sign flags; ex_stall_req=1 combinationally.
- Divisor=0 or (DIV/REM with -2^31 / -1): go directly to DONE.
- Otherwise go to CALC with count=0.
REQ-023 CALC:
- One restoring shift-subtract step per cycle; ex_stall_req=1.
- After count=DIV_ITERS-1, go to DONE.
REQ-024 DONE:
- ex_stall_req=0, ex_wr_data = signed-corrected result register.
- Quotient takes sign of (dividend XOR divisor); remainder takes the dividend sign.
- Next state IDLE.
REQ-025 Normal divide: ex_stall_req high 33 cycles (detect + 32 CALC); result valid in cycle 34.
REQ-026 Special divide cases: ex_stall_req high exactly 1 cycle; result in DONE.
- Divisor 0: quotient 32'hFFFFFFFF, remainder = dividend.
- Overflow: quotient 32'h80000000, remainder 0.
REQ-027 Flush (stall==6'b111111) in any state:
- FSM goes to IDLE next cycle; count cleared; no result produced.
- ex_stall_req is 0 in the flush cycle.
REQ-028 Divide in IDLE coinciding with flush: divide not started.
REQ-029 Bubble (alu_inst=0): all outputs 0.

Reset
REQ-030 While rst_n=0: FSM=IDLE, count, dividend/divisor/result registers, and sign flags = 0.
REQ-031 Reset mid-divide aborts the divide immediately; ex_stall_req=0 during reset.
REQ-032 First instruction after rst_n rises is decoded normally.

Structure
REQ-033 Opcode, funct3 and funct7 constants and FSM state encodings live in shared package cpu_defs_pkg.
REQ-034 Divider is sub-module ex_div, with:
- start, signed_op, rem_op, dividend, divisor, flush inputs;
- busy, done, result outputs.
- ALU, multiplier and branch logic stay in ex_unit.

Verification
REQ-035 ADDI x1 (op1=5, op2=-7) -> ex_wr_data=32'hFFFFFFFE, wr_en=1, no stall.
REQ-036 BLT with reg1=-1, reg2=1, jump addends 0x100 and 0x20 -> jump_flag=1, jump_addr=0x120.
REQ-037 DIV -7/2 -> stall_req high 33 cycles; DONE: wr_data=-3. REM -7/2 -> wr_data=-1.
REQ-038 DIVU 10/0 -> stall_req 1 cycle; wr_data=32'hFFFFFFFF. REM 0x80000000/-1 -> wr_data=0.
REQ-039 Flush at CALC count 10 -> stall_req=0 in the flush cycle, FSM IDLE next cycle; following ADD completes in 1 cycle.
REQ-040 rst_n low at CALC count 5 -> stall_req drops at once, all outputs 0.
- After release, MULHU 0xFFFFFFFF*0xFFFFFFFF -> wr_data=32'hFFFFFFFE.
